// File: rtl/parking_fee_calc.sv
// Parking-lot fee calculator: per-slot entry timestamps, and on exit a multi-cycle
// FSM that bills started units after a grace period, saturating at a fee cap.
module parking_fee_calc #(
    parameter int unsigned SLOT_W   = 3,
    parameter int unsigned FREE_MIN = 10,
    parameter int unsigned UNIT_MIN = 30,
    parameter int unsigned UNIT_FEE = 1000,
    parameter int unsigned MAX_FEE  = 30000
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [15:0]           time_now,
    input  logic                  entry_valid,
    input  logic [SLOT_W-1:0]     entry_slot,
    input  logic                  exit_valid,
    input  logic [SLOT_W-1:0]     exit_slot,
    output logic                  busy,
    output logic                  fee_valid,
    output logic [23:0]           fee,
    output logic [15:0]           duration,
    output logic [2**SLOT_W-1:0]  occupied,
    output logic [SLOT_W:0]       free_cnt,
    output logic                  err_occupied,
    output logic                  err_empty,
    output logic                  err_busy
);
    localparam int unsigned NS = 2**SLOT_W;
    localparam int unsigned CW = SLOT_W + 1;

    typedef enum logic [1:0] {IDLE, CALC, ACCUM, DONE} state_t;

    state_t              state;
    logic [15:0]         stamp [NS];
    logic [SLOT_W-1:0]   cur_slot;
    logic [15:0]         calc_dur;
    logic [15:0]         rem;
    logic [23:0]         acc;
    logic [15:0]         elapsed;
    logic [24:0]         acc_sum;
    logic                acc_sat;
    logic                entry_ok;
    logic [SLOT_W:0]     used;

    // Modulo-2**16 subtraction handles time_now wrap-around.
    assign elapsed  = time_now - stamp[cur_slot];
    assign acc_sum  = {1'b0, acc} + 25'(UNIT_FEE);
    assign acc_sat  = acc_sum >= 25'(MAX_FEE);
    assign busy     = (state != IDLE);
    assign entry_ok = (state == IDLE) && entry_valid && !exit_valid && !occupied[entry_slot];

    always_comb begin
        used = '0;
        for (int i = 0; i < NS; i++) begin
            used = used + CW'(occupied[i]);
        end
        free_cnt = CW'(NS) - used;
    end

    // Timestamp table is not reset; the occupied flags alone mark valid entries.
    always_ff @(posedge clk) begin
        if (entry_ok) begin
            stamp[entry_slot] <= time_now;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state        <= IDLE;
            occupied     <= '0;
            fee_valid    <= 1'b0;
            fee          <= '0;
            duration     <= '0;
            err_occupied <= 1'b0;
            err_empty    <= 1'b0;
            err_busy     <= 1'b0;
            cur_slot     <= '0;
            calc_dur     <= '0;
            rem          <= '0;
            acc          <= '0;
        end else begin
            fee_valid    <= 1'b0;
            err_occupied <= 1'b0;
            err_empty    <= 1'b0;
            err_busy     <= 1'b0;
            if (state != IDLE && (entry_valid || exit_valid)) begin
                err_busy <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (exit_valid) begin
                        // Exit wins over a simultaneous entry.
                        if (entry_valid) begin
                            err_busy <= 1'b1;
                        end
                        if (occupied[exit_slot]) begin
                            cur_slot <= exit_slot;
                            state    <= CALC;
                        end else begin
                            err_empty <= 1'b1;
                        end
                    end else if (entry_valid) begin
                        if (occupied[entry_slot]) begin
                            err_occupied <= 1'b1;
                        end else begin
                            occupied[entry_slot] <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    calc_dur <= elapsed;
                    rem      <= elapsed - 16'(FREE_MIN);
                    acc      <= '0;
                    state    <= (elapsed <= 16'(FREE_MIN)) ? DONE : ACCUM;
                end
                ACCUM: begin
                    acc <= acc_sat ? 24'(MAX_FEE) : acc_sum[23:0];
                    if (rem <= 16'(UNIT_MIN) || acc_sat) begin
                        state <= DONE;
                    end else begin
                        rem <= rem - 16'(UNIT_MIN);
                    end
                end
                DONE: begin
                    fee_valid          <= 1'b1;
                    fee                <= acc;
                    duration           <= calc_dur;
                    occupied[cur_slot] <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parking_fee_calc.sv
// Scoreboard bench for parking_fee_calc: expected fee/duration/latency queued at exit
// request time and compared when fee_valid pulses.
module tb_parking_fee_calc;
    localparam int FREE_MIN = 10;
    localparam int UNIT_MIN = 30;
    localparam int UNIT_FEE = 1000;
    localparam int MAX_FEE  = 30000;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [15:0] time_now = '0;
    logic        entry_valid = 1'b0;
    logic [2:0]  entry_slot = '0;
    logic        exit_valid = 1'b0;
    logic [2:0]  exit_slot = '0;
    logic        busy, fee_valid, err_occupied, err_empty, err_busy;
    logic [23:0] fee;
    logic [15:0] duration;
    logic [7:0]  occupied;
    logic [3:0]  free_cnt;

    typedef struct {
        logic [23:0] fee;
        logic [15:0] dur;
        int          cyc;
        int          slot;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] stamp_m [8];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;

    parking_fee_calc dut (
        .clk(clk), .reset_p(reset_p), .time_now(time_now),
        .entry_valid(entry_valid), .entry_slot(entry_slot),
        .exit_valid(exit_valid), .exit_slot(exit_slot),
        .busy(busy), .fee_valid(fee_valid), .fee(fee), .duration(duration),
        .occupied(occupied), .free_cnt(free_cnt),
        .err_occupied(err_occupied), .err_empty(err_empty), .err_busy(err_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic void model(input logic [15:0] st, input logic [15:0] t,
                                  output logic [23:0] f, output logic [15:0] d, output int n);
        int units;
        int cap;
        d = t - st;
        if (int'(d) <= FREE_MIN) begin
            f = '0;
            n = 0;
        end else begin
            units = (int'(d) - FREE_MIN + UNIT_MIN - 1) / UNIT_MIN;
            cap   = (MAX_FEE + UNIT_FEE - 1) / UNIT_FEE;
            n     = (units < cap) ? units : cap;
            f     = 24'((units * UNIT_FEE > MAX_FEE) ? MAX_FEE : units * UNIT_FEE);
        end
    endfunction

    always @(negedge clk) begin
        if (fee_valid) begin
            if (sb.size() == 0) begin
                check("spurious_fee_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("fee", 32'(fee), 32'(mon_e.fee));
                check("duration", 32'(duration), 32'(mon_e.dur));
                check("latency", cyc, mon_e.cyc);
                check("slot_freed", 32'(occupied[mon_e.slot]), 0);
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("fee_timeout", sb.size(), 0);
    endtask

    task automatic push_exp(input int slot, input logic [15:0] t);
        exp_t e;
        int   n;
        model(stamp_m[slot], t, e.fee, e.dur, n);
        e.cyc  = cyc + 3 + n;
        e.slot = slot;
        sb.push_back(e);
    endtask

    task automatic do_entry(input int slot, input logic [15:0] t, input bit expect_ok);
        @(negedge clk);
        time_now = t; entry_slot = 3'(slot); entry_valid = 1'b1;
        @(negedge clk);
        entry_valid = 1'b0;
        check("err_occupied", 32'(err_occupied), 32'(!expect_ok));
        check("occupied_set", 32'(occupied[slot]), 1);
        if (expect_ok) stamp_m[slot] = t;
    endtask

    task automatic do_exit(input int slot, input logic [15:0] t, input bit wait_it);
        @(negedge clk);
        push_exp(slot, t);
        time_now = t; exit_slot = 3'(slot); exit_valid = 1'b1;
        @(negedge clk);
        exit_valid = 1'b0;
        check("busy_after_exit", 32'(busy), 1);
        if (wait_it) wait_done();
    endtask

    initial begin
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_occupied", 32'(occupied), 0);
        check("rst_free_cnt", 32'(free_cnt), 8);
        check("rst_fee", 32'(fee), 0);
        check("rst_duration", 32'(duration), 0);
        check("rst_errs", {29'b0, err_occupied, err_empty, err_busy}, 0);
        repeat (2) @(negedge clk);
        reset_p = 1'b0;

        // Grace period, multi-unit, wrap-around, saturation.
        do_entry(2, 16'd100, 1'b1);
        check("free_cnt_one", 32'(free_cnt), 7);
        do_exit(2, 16'd105, 1'b1);
        check("free_cnt_back", 32'(free_cnt), 8);
        do_entry(2, 16'd100, 1'b1);
        do_exit(2, 16'd171, 1'b1);
        do_entry(0, 16'd65530, 1'b1);
        do_exit(0, 16'd20, 1'b1);
        do_entry(7, 16'd0, 1'b1);
        do_exit(7, 16'd2000, 1'b1);
        // rem exactly one unit, then one minute over.
        do_entry(4, 16'd1000, 1'b1);
        do_exit(4, 16'd1040, 1'b1);
        do_entry(4, 16'd1000, 1'b1);
        do_exit(4, 16'd1041, 1'b1);

        // Exit of an empty slot.
        @(negedge clk);
        exit_slot = 3'd5; exit_valid = 1'b1;
        @(negedge clk);
        exit_valid = 1'b0;
        check("err_empty", 32'(err_empty), 1);
        check("empty_busy", 32'(busy), 0);

        do_entry(2, 16'd50, 1'b1);
        do_entry(2, 16'd55, 1'b0);

        // Simultaneous entry + exit, then entry while busy. Duration == grace exactly.
        @(negedge clk);
        push_exp(2, 16'd60);
        time_now = 16'd60;
        entry_slot = 3'd1; entry_valid = 1'b1;
        exit_slot = 3'd2; exit_valid = 1'b1;
        @(negedge clk);
        exit_valid = 1'b0; entry_slot = 3'd3;
        check("sim_err_busy", 32'(err_busy), 1);
        check("sim_busy", 32'(busy), 1);
        check("sim_entry_dropped", 32'(occupied[1]), 0);
        @(negedge clk);
        entry_valid = 1'b0;
        check("busy_err_busy", 32'(err_busy), 1);
        check("busy_entry_dropped", 32'(occupied[3]), 0);
        wait_done();

        // Reset in the middle of a long accumulation.
        do_entry(6, 16'd0, 1'b1);
        do_exit(6, 16'd1000, 1'b0);
        repeat (5) @(negedge clk);
        sb.delete();
        reset_p = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_occupied", 32'(occupied), 0);
        check("abort_free_cnt", 32'(free_cnt), 8);
        @(negedge clk);
        reset_p = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/parking_fee_calc.md
PARKING_FEE_CALC -- requirements
Module: parking_fee_calc

Interface
REQ-001 SHALL have parameter SLOT_W, default 3, meaning slot index width; slot count NS = 2**SLOT_W.
REQ-002 SHALL have parameter FREE_MIN, default 10, meaning free grace period in minutes.
REQ-003 SHALL have parameter UNIT_MIN, default 30, meaning billing unit length in minutes (>=1).
REQ-004 SHALL have parameter UNIT_FEE, default 1000, meaning fee charged per started billing unit.
REQ-005 SHALL have parameter MAX_FEE, default 30000, meaning fee saturation cap (<2**24).
REQ-006 SHALL use clock clk; reset reset_p, asynchronous, active-high.
REQ-007 SHALL have ports (name, direction, width, meaning):
- clk  in  1  system clock
- reset_p  in  1  async active-high reset
- time_now  in  16  free-running minute count, wraps modulo 2**16
- entry_valid  in  1  car entering, sampled per clock
- entry_slot  in  SLOT_W  slot of entering car
- exit_valid  in  1  car leaving, sampled per clock
- exit_slot  in  SLOT_W  slot of leaving car
- busy  out  1  fee calculation in progress
- fee_valid  out  1  one-cycle pulse, fee/duration valid
- fee  out  24  fee of last completed exit, held until next fee_valid
- duration  out  16  parked minutes of last completed exit, held
- occupied  out  NS  per-slot occupancy flags
- free_cnt  out  SLOT_W+1  count of unoccupied slots
- err_occupied  out  1  one-cycle pulse, entry rejected
- err_empty  out  1  one-cycle pulse, exit rejected
- err_busy  out  1  one-cycle pulse, request dropped

Function
REQ-008 SHALL hold an NS-entry x 16-bit entry-timestamp table plus occupied flags.
REQ-009 SHALL implement FSM IDLE -> CALC -> ACCUM -> DONE -> IDLE; busy = (state != IDLE).
REQ-010 In IDLE, entry_valid on unoccupied slot SHALL write time_now to that slot and set its occupied bit at the same edge.
REQ-011 Entry on occupied slot SHALL leave table unchanged and pulse err_occupied next cycle.
REQ-012 In IDLE, exit_valid on unoccupied slot SHALL pulse err_empty next cycle; FSM stays IDLE.
REQ-013 In IDLE, exit_valid on occupied slot SHALL latch slot, move to CALC.
REQ-014 CALC SHALL compute duration = (time_now - stamp) mod 2**16 and rem = duration - FREE_MIN; fee accumulator cleared.
REQ-015 CALC SHALL go to DONE if duration <= FREE_MIN (fee 0), else to ACCUM.
REQ-016 Each ACCUM cycle SHALL add UNIT_FEE to fee, saturating at MAX_FEE; if rem <= UNIT_MIN or fee reaches MAX_FEE go to DONE, else rem -= UNIT_MIN.
REQ-017 Fee SHALL equal min(MAX_FEE, UNIT_FEE * ceil(rem/UNIT_MIN)); N = ACCUM cycles spent.
REQ-018 DONE SHALL assert fee_valid one cycle, update fee/duration, clear slot occupied bit, return IDLE.
REQ-019 Latency: with edge 0 sampling exit_valid, fee_valid SHALL be high in the cycle after edge 2+N.
REQ-020 Any entry_valid/exit_valid while busy SHALL be ignored and pulse err_busy.
REQ-021 Simultaneous entry_valid and exit_valid in IDLE: exit SHALL be processed (or rejected per REQ-012), entry dropped with err_busy.
REQ-022 free_cnt SHALL equal NS minus popcount(occupied), updated same cycle as occupied.
REQ-023 duration SHALL report full unsaturated elapsed minutes even when fee saturates.

Reset
REQ-024 reset_p SHALL immediately force FSM to IDLE, clear occupied, busy, fee_valid, fee, duration and all err pulses; free_cnt = NS.
REQ-025 Reset mid-calculation SHALL abort it with no fee_valid; table contents need not be cleared.

Verification
REQ-026 Entry slot 2 at time_now=100, exit slot 2 at 105 -> duration 5, fee 0, N=0, fee_valid after edge 2, occupied[2]=0.
REQ-027 Entry slot 2 at 100, exit at 171 -> duration 71, N=3, fee 3000, fee_valid after edge 5.
REQ-028 Entry slot 0 at 65530, exit at 20 -> duration 26, fee 1000 (wrap-around).
REQ-029 Entry slot 7 at 0, exit at 2000 -> duration 2000, fee 30000 after N=30 (saturation).
REQ-030 Exit empty slot 5 -> err_empty, busy stays 0; second entry slot 2 -> err_occupied; entry slot 1 + exit slot 2 same cycle -> exit processed, err_busy, occupied[1]=0; entry during busy -> err_busy.
REQ-031 reset_p asserted during ACCUM -> next cycle busy 0, occupied all 0, free_cnt 8, no fee_valid.
